// File: rtl/uart_pkg.sv
// Shared FSM state type and 8N1 frame constants for the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;

    // Index of the last data bit; the 3-bit bit counter wraps to 0 past it.
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: tick is high while the count sits at zero; load restarts it.
module uart_bit_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_rx.sv
// Full-duplex 8N1 UART, one byte in flight per direction.
// Define UART_LOOPBACK_EN to add i_loopback, which feeds o_tx_dout into the receiver.
module uart_tx_rx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT      = 434,
    parameter int TICKS_PER_BIT_SIZE = 9
) (
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef UART_LOOPBACK_EN
    input  logic       i_loopback,
`endif
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_tx_busy,
    output logic       o_tx_dout,
    input  logic       i_rx_enable,
    input  logic       i_rx_din,
    output logic [7:0] o_rx_data,
    output logic       o_rx_recv,
    output logic       o_rx_busy
);

    localparam logic [TICKS_PER_BIT_SIZE-1:0] BIT_RELOAD  = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] HALF_RELOAD = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t          tx_state, tx_state_next;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_next;
    logic [2:0]           tx_idx, tx_idx_next;
    logic                 tx_load, tx_tick, tx_end, tx_bit;
    logic                 tx_dout_q, tx_busy_q, tx_done_q;

    uart_bit_timer #(.WIDTH(TICKS_PER_BIT_SIZE)) u_tx_timer (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (tx_load),
        .load_value (BIT_RELOAD),
        .tick       (tx_tick)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_next = tx_state;
        tx_shift_next = tx_shift;
        tx_idx_next   = tx_idx;
        tx_load       = 1'b0;
        tx_end        = 1'b0;
        tx_bit        = STOP_BIT;
        case (tx_state)
            IDLE: begin
                if (i_tx_start) begin
                    tx_state_next = START;
                    tx_shift_next = i_tx_data;
                    tx_load       = 1'b1;
                end
            end
            START: begin
                tx_bit = START_BIT;
                if (tx_tick) begin
                    tx_state_next = DATA;
                    tx_idx_next   = '0;
                    tx_load       = 1'b1;
                end
            end
            DATA: begin
                tx_bit = tx_shift[0];
                if (tx_tick) begin
                    tx_load       = 1'b1;
                    tx_idx_next   = tx_idx + 3'd1;
                    tx_shift_next = tx_shift >> 1;
                    if (tx_idx == LAST_BIT_IDX) begin
                        tx_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tx_tick) begin
                    tx_end = 1'b1;
                    // Accepting here lets a held start chain frames with no idle gap.
                    if (i_tx_start) begin
                        tx_state_next = START;
                        tx_shift_next = i_tx_data;
                        tx_load       = 1'b1;
                    end else begin
                        tx_state_next = IDLE;
                    end
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= IDLE;
            tx_shift <= '0;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_state_next;
            tx_shift <= tx_shift_next;
            tx_idx   <= tx_idx_next;
        end
    end

    // Pin-facing outputs are registered so the serial line never glitches on state decode.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_dout_q <= STOP_BIT;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_dout_q <= tx_bit;
            tx_busy_q <= (tx_state != IDLE) && !tx_end;
            tx_done_q <= tx_end;
        end
    end

    assign o_tx_dout = tx_dout_q;
    assign o_tx_busy = tx_busy_q;
    assign o_tx_done = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_in, rx_meta, rx_line;

`ifdef UART_LOOPBACK_EN
    assign rx_in = i_loopback ? tx_dout_q : i_rx_din;
`else
    assign rx_in = i_rx_din;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_line <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_line <= rx_meta;
        end
    end

    uart_state_t                   rx_state, rx_state_next;
    logic [DATA_BITS-1:0]          rx_shift, rx_shift_next;
    logic [2:0]                    rx_idx, rx_idx_next;
    logic                          rx_err, rx_err_next;
    logic                          rx_load, rx_tick, rx_good;
    logic [TICKS_PER_BIT_SIZE-1:0] rx_reload;
    logic [DATA_BITS-1:0]          rx_data_q;
    logic                          rx_recv_q;

    uart_bit_timer #(.WIDTH(TICKS_PER_BIT_SIZE)) u_rx_timer (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (rx_load),
        .load_value (rx_reload),
        .tick       (rx_tick)
    );

    always_comb begin
        rx_state_next = rx_state;
        rx_shift_next = rx_shift;
        rx_idx_next   = rx_idx;
        rx_err_next   = rx_err;
        rx_load       = 1'b0;
        rx_reload     = BIT_RELOAD;
        rx_good       = 1'b0;
        case (rx_state)
            IDLE: begin
                if (i_rx_enable && rx_line == START_BIT) begin
                    rx_state_next = START;
                    rx_load       = 1'b1;
                    rx_reload     = HALF_RELOAD;
                end
            end
            START: begin
                if (rx_tick) begin
                    if (rx_line == STOP_BIT) begin
                        rx_state_next = IDLE;
                    end else begin
                        rx_state_next = DATA;
                        rx_idx_next   = '0;
                        rx_load       = 1'b1;
                    end
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_load       = 1'b1;
                    rx_idx_next   = rx_idx + 3'd1;
                    rx_shift_next = {rx_line, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == LAST_BIT_IDX) begin
                        rx_state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Timer is not reloaded, so tick stays high and a low stop bit
                // keeps polling the line every cycle until it returns high.
                if (rx_tick) begin
                    if (rx_line == STOP_BIT) begin
                        rx_state_next = IDLE;
                        rx_good       = !rx_err;
                        rx_err_next   = 1'b0;
                    end else begin
                        rx_err_next = 1'b1;
                    end
                end
            end
            default: rx_state_next = IDLE;
        endcase

        if (!i_rx_enable && rx_state != IDLE) begin
            rx_state_next = IDLE;
            rx_err_next   = 1'b0;
            rx_load       = 1'b0;
            rx_good       = 1'b0;
        end
    end

    // NOTE: the data registers are reset as well so o_rx_data starts at a defined 0x00.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state  <= IDLE;
            rx_shift  <= '0;
            rx_idx    <= '0;
            rx_err    <= 1'b0;
            rx_data_q <= '0;
            rx_recv_q <= 1'b0;
        end else begin
            rx_state  <= rx_state_next;
            rx_shift  <= rx_shift_next;
            rx_idx    <= rx_idx_next;
            rx_err    <= rx_err_next;
            rx_recv_q <= rx_good;
            if (rx_good) begin
                rx_data_q <= rx_shift;
            end
        end
    end

    assign o_rx_data = rx_data_q;
    assign o_rx_recv = rx_recv_q;
    assign o_rx_busy = (rx_state != IDLE);

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed/randomized bench for uart_tx_rx with a frame-level reference model.
module tb_uart_tx_rx;

    localparam int TPB   = 4;
    localparam int FRAME = 10 * TPB;
    localparam int LOG_N = 4096;
    localparam int RX_MAX_LAT = 2 + TPB / 2 + 9 * TPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_enable = 1'b0;
    logic       bb_din = 1'b1;
    logic       use_loop = 1'b0;
    logic       rx_din;
    logic       tx_done, tx_busy, tx_dout;
    logic [7:0] rx_data;
    logic       rx_recv, rx_busy;

    assign rx_din = use_loop ? tx_dout : bb_din;

    uart_tx_rx #(
        .TICKS_PER_BIT      (TPB),
        .TICKS_PER_BIT_SIZE (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef UART_LOOPBACK_EN
        .i_loopback  (use_loop),
`endif
        .i_tx_start  (tx_start),
        .i_tx_data   (tx_data),
        .o_tx_done   (tx_done),
        .o_tx_busy   (tx_busy),
        .o_tx_dout   (tx_dout),
        .i_rx_enable (rx_enable),
        .i_rx_din    (rx_din),
        .o_rx_data   (rx_data),
        .o_rx_recv   (rx_recv),
        .o_rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen; the interval after edge n logs at index n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       dout_log [LOG_N];
    logic       done_log [LOG_N];
    logic       busy_log [LOG_N];
    int         recv_cnt = 0;
    int         done_cnt = 0;
    int         recv_cyc = 0;
    int         stray_changes = 0;
    logic [7:0] recv_q[$];
    logic [7:0] prev_rx_data = 8'h00;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            dout_log[cyc] = tx_dout;
            done_log[cyc] = tx_done;
            busy_log[cyc] = tx_busy;
        end
        if (rx_recv === 1'b1) begin
            recv_cnt++;
            recv_cyc = cyc;
            recv_q.push_back(rx_data);
        end
        if (tx_done === 1'b1) done_cnt++;
        if (rst !== 1'b1 && rx_data !== prev_rx_data && rx_recv !== 1'b1) stray_changes++;
        prev_rx_data = rx_data;
    end

    int n_cmp = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bench actions happen just after a falling edge, well away from the active edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference frame: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return d[j-1];
    endfunction

    task automatic rx_send(input logic [7:0] d, input logic stop_val);
        for (int b = 0; b < 10; b++) begin
            bb_din = (b == 9) ? stop_val : frame_bit(d, b);
            step(TPB);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, output int k);
        int guard = 0;
        while (tx_busy !== 1'b0 && guard < 3 * FRAME) begin
            step(1);
            guard++;
        end
        check("tx_idle_before_start", tx_busy, 1'b0);
        tx_data  = d;
        tx_start = 1'b1;
        k        = cyc + 1;
        step(1);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Frame accepted at edge k: line low from edge k+1, one bit per TPB cycles,
    // done and busy=0 in the final stop-bit cycle (after edge k+FRAME).
    task automatic verify_tx(input string tag, input logic [7:0] d, input int k);
        logic [9:0] seen, want;
        while (cyc < k + FRAME + 2) step(1);
        for (int b = 0; b < 10; b++) begin
            seen[b] = dout_log[k + 1 + b * TPB + TPB / 2];
            want[b] = frame_bit(d, b);
        end
        check({tag, "_bits"}, seen, want);
        check({tag, "_edges"}, {dout_log[k], dout_log[k + 1], dout_log[k + FRAME]}, 3'b101);
        check({tag, "_done"}, {done_log[k + FRAME - 1], done_log[k + FRAME], done_log[k + FRAME + 1]}, 3'b010);
        check({tag, "_busy"}, {busy_log[k], busy_log[k + 1], busy_log[k + FRAME]}, 3'b010);
    endtask

    initial begin
        int         k, k2, f, r0, dc0;
        logic [7:0] d, keep;
        logic       saw;

        // Reset state
        step(3);
        check("rst_tx_dout", tx_dout, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_recv", rx_recv, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        rst = 1'b0;
        rx_enable = 1'b1;
        step(2);

        // Bit-banged 0xAB, with latency bound
        r0 = recv_cnt;
        f  = cyc;
        rx_send(8'hAB, 1'b1);
        step(4);
        check("rx_ab_data", rx_data, 8'hAB);
        check("rx_ab_pulses", recv_cnt - r0, 1);
        check("rx_ab_busy", rx_busy, 1'b0);
        check("rx_ab_latency_ok", (recv_cyc - f) <= RX_MAX_LAT, 1'b1);

        // Random received bytes, near back-to-back
        for (int i = 0; i < 4; i++) begin
            d  = 8'($urandom);
            r0 = recv_cnt;
            rx_send(d, 1'b1);
            step(2);
            check("rx_rand_data", rx_data, d);
            check("rx_rand_pulses", recv_cnt - r0, 1);
        end

        // Framing error: stop bit low, line stays low, then recovers
        keep = rx_data;
        r0   = recv_cnt;
        rx_send(8'h55, 1'b0);
        step(2 * TPB);
        check("ferr_hold_busy", rx_busy, 1'b1);
        bb_din = 1'b1;
        step(4);
        check("ferr_busy_clear", rx_busy, 1'b0);
        check("ferr_no_pulse", recv_cnt - r0, 0);
        check("ferr_data_kept", rx_data, keep);
        d = 8'($urandom);
        rx_send(d, 1'b1);
        step(2);
        check("ferr_resume_data", rx_data, d);

        // One-cycle glitch
        r0     = recv_cnt;
        bb_din = 1'b0;
        step(1);
        bb_din = 1'b1;
        saw    = 1'b0;
        for (int i = 0; i < TPB / 2 + 2; i++) begin
            step(1);
            saw |= rx_busy;
        end
        check("glitch_detected", saw, 1'b1);
        check("glitch_busy_clear", rx_busy, 1'b0);
        check("glitch_no_pulse", recv_cnt - r0, 0);

        // Receiver disabled, then abort mid-frame
        rx_enable = 1'b0;
        r0 = recv_cnt;
        rx_send(8'($urandom), 1'b1);
        step(2);
        check("dis_busy", rx_busy, 1'b0);
        check("dis_no_pulse", recv_cnt - r0, 0);
        rx_enable = 1'b1;
        step(2);
        bb_din = 1'b0;
        step(3 * TPB);
        check("abort_busy_before", rx_busy, 1'b1);
        rx_enable = 1'b0;
        bb_din    = 1'b1;
        step(1);
        check("abort_busy_after", rx_busy, 1'b0);
        step(2);
        rx_enable = 1'b1;
        step(8 * TPB);
        check("abort_no_pulse", recv_cnt - r0, 0);

        // TX frames; a mid-frame start with different data must be ignored
        for (int i = 0; i < 3; i++) begin
            d   = 8'($urandom);
            dc0 = done_cnt;
            start_tx(d, k);
            step(3 * TPB);
            tx_data  = ~d;
            tx_start = 1'b1;
            step(1);
            tx_start = 1'b0;
            verify_tx("tx_rand", d, k);
            check("tx_rand_done_count", done_cnt - dc0, 1);
            check("tx_rand_idle_after", tx_busy, 1'b0);
        end

        // Loopback: transmitter feeds the receiver
        use_loop = 1'b1;
        step(2);
        for (int i = 0; i < 3; i++) begin
            d  = (i == 0) ? 8'h0D : 8'($urandom);
            r0 = recv_cnt;
            start_tx(d, k);
            verify_tx("lb", d, k);
            step(4);
            check("lb_rx_data", rx_data, d);
            check("lb_rx_pulses", recv_cnt - r0, 1);
        end

        // Back-to-back 0x00 then 0xFF with start held high
        r0       = recv_cnt;
        dc0      = done_cnt;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        k        = cyc + 1;
        step(1);
        tx_data = 8'hFF;
        k2      = k + FRAME;
        while (cyc < k2) step(1);
        tx_start = 1'b0;
        verify_tx("b2b_first", 8'h00, k);
        verify_tx("b2b_second", 8'hFF, k2);
        step(4);
        check("b2b_done_count", done_cnt - dc0, 2);
        check("b2b_rx_pulses", recv_cnt - r0, 2);
        check("b2b_rx_first", recv_q[recv_q.size() - 2], 8'h00);
        check("b2b_rx_second", recv_q[recv_q.size() - 1], 8'hFF);

        // Reset in the middle of a frame on both directions
        r0  = recv_cnt;
        dc0 = done_cnt;
        start_tx(8'($urandom), k);
        step(15);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_dout", tx_dout, 1'b1);
        check("mid_rst_tx_busy", tx_busy, 1'b0);
        check("mid_rst_rx_busy", rx_busy, 1'b0);
        check("mid_rst_tx_done", tx_done, 1'b0);
        step(2);
        rst = 1'b0;
        step(2 * FRAME);
        check("mid_rst_no_done", done_cnt - dc0, 0);
        check("mid_rst_no_recv", recv_cnt - r0, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);

        d  = 8'($urandom);
        r0 = recv_cnt;
        start_tx(d, k);
        verify_tx("post_rst", d, k);
        step(4);
        check("post_rst_rx_data", rx_data, d);
        check("post_rst_rx_pulses", recv_cnt - r0, 1);

        check("rx_data_only_with_recv", stray_changes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
        $finish;
    end

endmodule
